// File: rtl/sdram_req_pkg.sv
// Shared types and constants for the SDRAM burst requester.
package sdram_req_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWrReq  = 3'd1,
    StWrXfer = 3'd2,
    StRdReq  = 3'd3,
    StRdXfer = 3'd4
  } state_e;

  localparam int unsigned DEFAULT_BURST_LEN   = 256;
  localparam int unsigned DEFAULT_FRAME_WORDS = 130560;

  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

endpackage

// File: rtl/sdram_addr_gen.sv
// Burst start-address counter: steps by LEN, wraps to BASE at the end of the frame
// and pulses wrap for one cycle when that happens.
module sdram_addr_gen #(
  parameter int unsigned        ADDR_W = 22,
  parameter logic [ADDR_W-1:0]  BASE   = '0,
  parameter int unsigned        LEN    = 256,
  parameter int unsigned        WORDS  = 130560
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              restart,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(LEN);
  localparam logic [ADDR_W-1:0] END_ADDR = BASE + ADDR_W'(WORDS);

  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic              wrap_q, wrap_d;

  always_comb begin
    addr_inc = addr_q + STEP;
    addr_d   = addr_q;
    wrap_d   = 1'b0;
    // A restart overrides a coincident advance and never reports a wrap.
    if (restart) begin
      addr_d = BASE;
    end else if (advance) begin
      if (addr_inc == END_ADDR) begin
        addr_d = BASE;
        wrap_d = 1'b1;
      end else begin
        addr_d = addr_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= BASE;
      wrap_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      wrap_q <= wrap_d;
    end
  end

  assign addr = addr_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/sdram_req_ctrl.sv
// User-side SDRAM burst requester: arbitrates write-FIFO drain against read-FIFO fill
// and issues fixed-length burst requests with frame-wrapping addresses.
module sdram_req_ctrl
  import sdram_req_pkg::*;
#(
  parameter int unsigned       BURST_LEN   = DEFAULT_BURST_LEN,
  parameter int unsigned       ADDR_W      = 22,
  parameter int unsigned       CNT_W       = 10,
  parameter int unsigned       RDF_DEPTH   = 512,
  parameter logic [ADDR_W-1:0] WR_BASE     = '0,
  parameter logic [ADDR_W-1:0] RD_BASE     = '0,
  parameter int unsigned       FRAME_WORDS = DEFAULT_FRAME_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdram_init_done,
  input  logic [CNT_W-1:0]  wrf_usedw,
  input  logic [CNT_W-1:0]  rdf_usedw,
  input  logic              rd_en,
  input  logic              rd_restart,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack,
  output logic [ADDR_W-1:0] sys_wraddr,
  output logic [ADDR_W-1:0] sys_rdaddr,
  output logic [8:0]        sdwr_byte,
  output logic [8:0]        sdrd_byte,
  output logic              wrf_rd_en,
  output logic              rdf_wr_en,
  output logic              wr_frame_done
);

  localparam logic [CNT_W:0] WR_THRESH = (CNT_W + 1)'(BURST_LEN);
  localparam logic [CNT_W:0] RD_THRESH = (CNT_W + 1)'(RDF_DEPTH - BURST_LEN);

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   restart_pend_q, restart_pend_d;
  logic   wr_pend, rd_pend, in_rd;
  logic   wr_done, rd_done, rd_load_base;
  logic   unused_rd_wrap;

  assign wr_pend = {1'b0, wrf_usedw} >= WR_THRESH;
  assign rd_pend = rd_en && ({1'b0, rdf_usedw} <= RD_THRESH);
  assign in_rd   = (state_q == StRdReq) || (state_q == StRdXfer);

  assign sdwr_byte = 9'(BURST_LEN);
  assign sdrd_byte = 9'(BURST_LEN);

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    restart_pend_d = restart_pend_q;
    wr_done        = 1'b0;
    rd_done        = 1'b0;
    rd_load_base   = 1'b0;
    sdram_wr_req   = 1'b0;
    sdram_rd_req   = 1'b0;
    wrf_rd_en      = 1'b0;
    rdf_wr_en      = 1'b0;

    if (rd_restart) begin
      if (in_rd) begin
        restart_pend_d = 1'b1;
      end else begin
        rd_load_base = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (sdram_init_done) begin
          if (wr_pend && (!rd_pend || last_grant_q == GRANT_RD)) begin
            state_d = StWrReq;
          end else if (rd_pend) begin
            state_d = StRdReq;
          end
        end
      end
      // The first data beat coincides with the ack being sampled in REQ, so it strobes too.
      StWrReq: begin
        sdram_wr_req = 1'b1;
        wrf_rd_en    = sdram_wr_ack;
        if (sdram_wr_ack) state_d = StWrXfer;
      end
      StWrXfer: begin
        wrf_rd_en = sdram_wr_ack;
        if (!sdram_wr_ack) begin
          wr_done      = 1'b1;
          last_grant_d = GRANT_WR;
          state_d      = StIdle;
        end
      end
      StRdReq: begin
        sdram_rd_req = 1'b1;
        rdf_wr_en    = sdram_rd_ack;
        if (sdram_rd_ack) state_d = StRdXfer;
      end
      StRdXfer: begin
        rdf_wr_en = sdram_rd_ack;
        if (!sdram_rd_ack) begin
          rd_done        = 1'b1;
          last_grant_d   = GRANT_RD;
          state_d        = StIdle;
          rd_load_base   = restart_pend_q || rd_restart;
          restart_pend_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      last_grant_q   <= GRANT_RD;
      restart_pend_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      restart_pend_q <= restart_pend_d;
    end
  end

  sdram_addr_gen #(
    .ADDR_W (ADDR_W),
    .BASE   (WR_BASE),
    .LEN    (BURST_LEN),
    .WORDS  (FRAME_WORDS)
  ) u_wr_addr (
    .clk     (clk),
    .rst     (rst),
    .advance (wr_done),
    .restart (1'b0),
    .addr    (sys_wraddr),
    .wrap    (wr_frame_done)
  );

  sdram_addr_gen #(
    .ADDR_W (ADDR_W),
    .BASE   (RD_BASE),
    .LEN    (BURST_LEN),
    .WORDS  (FRAME_WORDS)
  ) u_rd_addr (
    .clk     (clk),
    .rst     (rst),
    .advance (rd_done),
    .restart (rd_load_base),
    .addr    (sys_rdaddr),
    .wrap    (unused_rd_wrap)
  );

endmodule
